// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter: shares one memory request port between instruction
// fetch and load/store. At most one transaction is in flight; each response
// is routed back to the requester that owns the current transaction.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_req_ready,
    output logic                if_resp_valid,
    output logic [DATA_W-1:0]   if_resp_rdata,
    input  logic                ls_req_valid,
    input  logic                ls_req_write,
    input  logic [ADDR_W-1:0]   ls_req_addr,
    input  logic [DATA_W-1:0]   ls_req_wdata,
    input  logic [DATA_W/8-1:0] ls_req_wstrb,
    output logic                ls_req_ready,
    output logic                ls_resp_valid,
    output logic [DATA_W-1:0]   ls_resp_rdata,
    output logic                mem_req_valid,
    output logic                mem_req_write,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wstrb,
    input  logic                mem_req_ready,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_rdata
);

    localparam int unsigned SW = ($clog2(STARVE_LIMIT + 1) < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state, state_nx;
    logic          own;
    logic [SW-1:0] starve_cnt;
    logic          ls_win;
    logic          if_win;
    logic          resp_fire;

    // Load/store wins ties unless fetch has been passed over STARVE_LIMIT times.
    always_comb begin
        ls_win = ls_req_valid && !(if_req_valid && (starve_cnt == LIMIT));
        if_win = if_req_valid && !ls_win;
    end

    // Next state, upstream readys and response routing.
    always_comb begin
        state_nx      = state;
        if_req_ready  = 1'b0;
        ls_req_ready  = 1'b0;
        resp_fire     = 1'b0;
        case (state)
            IDLE: begin
                if (ls_win || if_win) begin
                    ls_req_ready = ls_win;
                    if_req_ready = if_win;
                    state_nx     = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    resp_fire = mem_resp_valid;
                    state_nx  = mem_resp_valid ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    resp_fire = 1'b1;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if_resp_valid = resp_fire && !own;
        ls_resp_valid = resp_fire && own;
        if_resp_rdata = mem_resp_rdata;
        ls_resp_rdata = mem_resp_rdata;
        mem_req_valid = (state == ISSUE);
    end

    // State, owner, starvation counter and latched request fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            own           <= 1'b0;
            starve_cnt    <= '0;
            mem_req_write <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wstrb <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                if (ls_win) begin
                    own           <= 1'b1;
                    mem_req_write <= ls_req_write;
                    mem_req_addr  <= ls_req_addr;
                    mem_req_wdata <= ls_req_wdata;
                    mem_req_wstrb <= ls_req_wstrb;
                    if (!if_req_valid)
                        starve_cnt <= '0;
                    else if (starve_cnt != LIMIT)
                        starve_cnt <= starve_cnt + 1'b1;
                end else if (if_win) begin
                    own           <= 1'b0;
                    mem_req_write <= 1'b0;
                    mem_req_addr  <= if_req_addr;
                    mem_req_wdata <= '0;
                    mem_req_wstrb <= '0;
                    starve_cnt    <= '0;
                end
            end
        end
    end

endmodule
